// File: rtl/ahb_bridge_arbiter_pkg.sv
// Shared definitions for the AHB bridge arbiter: htrans encodings, arbiter
// state enum and a constant-friendly clog2 helper.
// Optional feature macro used by this slice: AHB_ARB_LOCK_EN.
package ahb_arb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    ST_PARK   = 2'b00,
    ST_OWNED  = 2'b01,
    ST_LOCKED = 2'b10
  } arb_state_e;

  // Ceiling log2, never less than 1 so it can size an ID field directly.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // NONSEQ and SEQ are the only transfer types that move data.
  function automatic logic is_beat(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_bridge_arbiter_if.sv
// Arbiter-side bus bundle: request/lock vectors and muxed transfer status in,
// grant, owner ID and lock status out.
// Optional feature macro used by this slice: AHB_ARB_LOCK_EN.
interface ahb_bridge_arbiter_if #(
  parameter int NUM_MASTERS = 4
);
  import ahb_arb_pkg::*;

  localparam int MID_W = clog2(NUM_MASTERS);

  logic [NUM_MASTERS-1:0] hbusreq;
  logic [NUM_MASTERS-1:0] hlock;
  logic [1:0]             htrans;
  logic                   hready;
  logic [NUM_MASTERS-1:0] hgrant;
  logic [MID_W-1:0]       hmaster;
  logic                   hmastlock;

  // Arbiter view.
  modport slave (
    input  hbusreq, hlock, htrans, hready,
    output hgrant, hmaster, hmastlock
  );

  // Requester / bridge view.
  modport master (
    output hbusreq, hlock, htrans, hready,
    input  hgrant, hmaster, hmastlock
  );

endinterface

// File: rtl/ahb_bridge_arbiter_rr_pick.sv
// Combinational round-robin selector: returns the first requester strictly
// after the pointer, wrapping, so the pointer itself has lowest priority.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  // Scan farthest-first so the nearest requester after the pointer wins.
  always_comb begin : p_scan
    int l_idx;
    // NOTE: every output gets a default before any condition so no latch is inferred.
    l_idx   = 0;
    o_idx   = '0;
    o_valid = 1'b0;
    o_grant = '0;
    for (int k = N; k >= 1; k--) begin
      l_idx = (int'(i_ptr) + k) % N;
      if (i_req[l_idx]) begin
        o_idx   = IDX_W'(l_idx);
        o_valid = 1'b1;
      end
    end
    if (o_valid) o_grant[o_idx] = 1'b1;
  end

endmodule

// File: rtl/ahb_bridge_arbiter.sv
// Round-robin arbiter sharing one AHB-to-APB bridge slave port between
// NUM_MASTERS masters. Grant handover happens only on hready=1 edges, is
// limited by a per-owner tenure count and frozen during locked sequences.
// Optional feature macro: AHB_ARB_LOCK_EN (honour hlock, LOCKED state,
// drive hmastlock); undefined builds ignore hlock and tie hmastlock low.
module ahb_bridge_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0,
  parameter int MAX_TENURE     = 8
) (
  input logic                 hclk,
  input logic                 hresetn,
  ahb_bridge_arbiter_if.slave bus
);

  localparam int MID_W = clog2(NUM_MASTERS);
  localparam int TEN_W = clog2(MAX_TENURE + 1);
  localparam logic [MID_W-1:0]       DEF_ID    = MID_W'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [TEN_W-1:0]       TEN_LIMIT = TEN_W'(MAX_TENURE);

  arb_state_e             r_state;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [MID_W-1:0]       r_ptr;       // last owner; round-robin origin
  logic [MID_W-1:0]       r_master;
  logic                   r_mastlock;
  logic [TEN_W-1:0]       r_tenure;

  arb_state_e             w_state_nxt;
  logic [NUM_MASTERS-1:0] w_grant_nxt;
  logic [MID_W-1:0]       w_ptr_nxt;
  logic [TEN_W-1:0]       w_tenure_nxt;
  logic                   w_mastlock_nxt;
  logic                   w_award;
  logic                   w_park;
  logic [NUM_MASTERS-1:0] w_pick_grant;
  logic [MID_W-1:0]       w_pick_idx;
  logic                   w_pick_valid;
  logic [MID_W-1:0]       w_grant_idx;
  logic                   w_beat;
  logic                   w_owner_req;
  logic                   w_others_req;
  logic                   w_tenure_full;
  logic                   w_lock_hold;

  rr_pick #(
    .N     (NUM_MASTERS),
    .IDX_W (MID_W)
  ) u_rr_pick (
    .i_req   (bus.hbusreq),
    .i_ptr   (r_ptr),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  assign w_beat        = is_beat(bus.htrans);
  assign w_owner_req   = bus.hbusreq[r_ptr];
  assign w_others_req  = |(bus.hbusreq & ~r_grant);
  assign w_tenure_full = (r_tenure == TEN_LIMIT);

`ifdef AHB_ARB_LOCK_EN
  assign w_lock_hold    = bus.hlock[r_ptr] && w_beat;
  assign w_mastlock_nxt = bus.hlock[w_grant_idx];
`else
  assign w_lock_hold    = 1'b0;
  assign w_mastlock_nxt = 1'b0;
`endif

  // Encode the current one-hot grant into the ID that the next address phase carries.
  always_comb begin
    w_grant_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (r_grant[i]) w_grant_idx = MID_W'(i);
    end
  end

  // Next-state and next-grant decision, evaluated every cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    w_award     = 1'b0;
    w_park      = 1'b0;
    unique case (r_state)
      ST_PARK: begin
        if (w_pick_valid) w_award = 1'b1;
      end
      ST_OWNED: begin
        if (w_lock_hold) begin
          w_state_nxt = ST_LOCKED;
        end else if (!w_owner_req || (w_tenure_full && w_others_req)) begin
          // Owner drop with a waiting requester hands over directly, no idle gap.
          if (w_pick_valid) w_award = 1'b1;
          else              w_park  = 1'b1;
        end
      end
`ifdef AHB_ARB_LOCK_EN
      ST_LOCKED: begin
        // Unlock once the beat after hlock drops completes; re-arbitrate next.
        if (!bus.hlock[r_ptr]) w_state_nxt = ST_OWNED;
      end
`endif
      default: w_park = 1'b1;
    endcase
    if (w_award) begin
      w_state_nxt = ST_OWNED;
      w_grant_nxt = w_pick_grant;
      w_ptr_nxt   = w_pick_idx;
    end
    if (w_park) begin
      w_state_nxt = ST_PARK;
      w_grant_nxt = DEF_GRANT;
    end
  end

  // Tenure restarts with every new owner and while parked; saturates at the limit.
  always_comb begin
    w_tenure_nxt = r_tenure;
    if (w_award || (w_state_nxt == ST_PARK)) begin
      w_tenure_nxt = '0;
    end else if (w_beat && !w_tenure_full) begin
      w_tenure_nxt = r_tenure + 1'b1;
    end
  end

  // State, grant and round-robin pointer advance only on accepted (hready=1) edges.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_state <= ST_PARK;
      r_grant <= DEF_GRANT;
      r_ptr   <= DEF_ID;
    end else if (bus.hready) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Address-phase owner, lock flag and tenure follow the grant by one accepted transfer.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_master   <= DEF_ID;
      r_mastlock <= 1'b0;
      r_tenure   <= '0;
    end else if (bus.hready) begin
      r_master   <= w_grant_idx;
      r_mastlock <= w_mastlock_nxt;
      r_tenure   <= w_tenure_nxt;
    end
  end

  assign bus.hgrant    = r_grant;
  assign bus.hmaster   = r_master;
  assign bus.hmastlock = r_mastlock;

endmodule
